// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the 25 MHz pixel clock domain.
// The display stays idle until the PLL lock has been stable for LOCK_WAIT
// cycles. After that it produces hsync/vsync/de and x/y coordinates, all
// taken straight from flops. Optional macro VGA_TIMING_FRAME_CNT_EN adds a
// 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int LOCK_WAIT = 1024,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clkp,
  input  logic       rstn,
  input  logic       locked,
  output logic       running,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The coordinate counters are 10 bits wide, so neither total may exceed 1024.
  if (H_TOTAL > 1024) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (LOCK_WAIT < 1) begin : g_bad_lockwait
    $error("vga_timing_gen: LOCK_WAIT must be at least 1");
  end

  // Decode limits are 11 bits wide so a sync window ending exactly at 1024 still fits.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [1:0]      lock_sync;
  logic            lk;

  logic            run_n;
  logic [9:0]      x_n;
  logic [9:0]      y_n;
  logic            de_n;
  logic            hsync_n;
  logic            vsync_n;
  logic            line_start_n;
  logic            frame_start_n;

  // Two-flop synchronizer for the asynchronous PLL lock signal.
  always_ff @(posedge clkp) begin
    if (!rstn) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], locked};
    end
  end

  assign lk = lock_sync[1];

  // Next state, settle counter and next raster position; outputs default to idle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    run_n   = 1'b0;
    x_n     = 10'd0;
    y_n     = 10'd0;
    case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lk) begin
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (!lk) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
          run_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (!lk) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          run_n = 1'b1;
          if (x == H_LAST) begin
            x_n = 10'd0;
            y_n = (y == V_LAST) ? 10'd0 : y + 10'd1;
          end else begin
            x_n = x + 10'd1;
            y_n = y;
          end
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  // Decode the upcoming position so the registered strobes line up with x/y.
  always_comb begin
    de_n          = 1'b0;
    hsync_n       = ~HSYNC_POL;
    vsync_n       = ~VSYNC_POL;
    line_start_n  = 1'b0;
    frame_start_n = 1'b0;
    if (run_n) begin
      de_n = ({1'b0, x_n} < H_VIS) && ({1'b0, y_n} < V_VIS);
      if (({1'b0, x_n} >= HS_BEGIN) && ({1'b0, x_n} < HS_END)) begin
        hsync_n = HSYNC_POL;
      end
      if (({1'b0, y_n} >= VS_BEGIN) && ({1'b0, y_n} < VS_END)) begin
        vsync_n = VSYNC_POL;
      end
      line_start_n  = (x_n == 10'd0);
      frame_start_n = (x_n == 10'd0) && (y_n == 10'd0);
    end
  end

  // State, settle counter and every output are registered here.
  always_ff @(posedge clkp) begin
    if (!rstn) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      running     <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      running     <= run_n;
      x           <= x_n;
      y           <= y_n;
      de          <= de_n;
      hsync       <= hsync_n;
      vsync       <= vsync_n;
      line_start  <= line_start_n;
      frame_start <= frame_start_n;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter survives lock loss; it steps once after each frame_start pulse.
  always_ff @(posedge clkp) begin
    if (!rstn) begin
      frame_cnt <= 16'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen using a reduced raster
// (32 x 13 totals, LOCK_WAIT=4) so whole frames fit in a short run. A lock-history
// model predicts every output cycle by cycle; literal checks pin the model.
module tb_vga_timing_gen;

  localparam int HA = 20, HFP = 3, HSW = 5, HBP = 4;
  localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 3;
  localparam int LW = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  logic       clkp = 1'b0;
  logic       rstn;
  logic       locked;
  logic       running, hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;
  bit done = 1'b0;

  // model state: lock streak lengths one and two samples back
  int st1 = 0, st2 = 0;
  int run_len, new_st, k;
  logic m_run = 1'b0, m_de = 1'b0, m_hs = 1'b1, m_vs = 1'b1, m_ls = 1'b0, m_fs = 1'b0;
  int m_x = 0, m_y = 0;
  int m_fcnt = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .LOCK_WAIT(LW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clkp(clkp),
    .rstn(rstn),
    .locked(locked),
    .running(running),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .x(x),
    .y(y),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  // 25 MHz-style free-running clock (period 10 time units).
  always #5 clkp = ~clkp;

  // Model: the display runs once lock has been sampled high for LOCK_WAIT+1
  // consecutive edges, observed two edges late through the synchronizer.
  always @(posedge clkp) begin
    edge_no = edge_no + 1;
    if (!rstn) begin
      st1 = 0;
      st2 = 0;
      m_fcnt = 0;
      run_len = 0;
    end else begin
      if (m_fs) m_fcnt = (m_fcnt + 1) % 65536;
      run_len = st2;
      new_st = locked ? st1 + 1 : 0;
      st2 = st1;
      st1 = new_st;
    end
    m_run = (run_len >= LW + 1);
    if (m_run) begin
      k    = run_len - (LW + 1);
      m_x  = k % HT;
      m_y  = (k / HT) % VT;
      m_de = (m_x < HA) && (m_y < VA);
      m_hs = !((m_x >= HA + HFP) && (m_x < HA + HFP + HSW));
      m_vs = !((m_y >= VA + VFP) && (m_y < VA + VFP + VSW));
      m_ls = (m_x == 0);
      m_fs = (m_x == 0) && (m_y == 0);
    end else begin
      m_x = 0; m_y = 0;
      m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_ls = 1'b0; m_fs = 1'b0;
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s edge=%0d got=%0h want=%0h", nm, edge_no, act, exp);
    end
  endtask

  task automatic go_to(input int n);
    while (edge_no < n) @(negedge clkp);
  endtask

  task automatic applyStimulus(input int at_edge, input logic lk_v, input logic rst_v);
    go_to(at_edge);
    locked = lk_v;
    rstn   = rst_v;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clkp) begin
    if (edge_no >= 1 && !done) begin
      checkOutput("m.running", 32'(running), 32'(m_run));
      checkOutput("m.x", 32'(x), 32'(m_x));
      checkOutput("m.y", 32'(y), 32'(m_y));
      checkOutput("m.de", 32'(de), 32'(m_de));
      checkOutput("m.hsync", 32'(hsync), 32'(m_hs));
      checkOutput("m.vsync", 32'(vsync), 32'(m_vs));
      checkOutput("m.line_start", 32'(line_start), 32'(m_ls));
      checkOutput("m.frame_start", 32'(frame_start), 32'(m_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
      checkOutput("m.frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
    end
  end

  task automatic check_idle(input string tag);
    checkOutput({tag, ".running"}, 32'(running), 32'd0);
    checkOutput({tag, ".x"}, 32'(x), 32'd0);
    checkOutput({tag, ".y"}, 32'(y), 32'd0);
    checkOutput({tag, ".de"}, 32'(de), 32'd0);
    checkOutput({tag, ".hsync"}, 32'(hsync), 32'd1);
    checkOutput({tag, ".vsync"}, 32'(vsync), 32'd1);
  endtask

  initial begin
    int de_acc, hs_acc, vs_acc;
    rstn   = 1'b0;
    locked = 1'b1;

    // reset held for three edges with lock high
    go_to(3);
    check_idle("reset");
    checkOutput("reset.frame_start", 32'(frame_start), 32'd0);
    applyStimulus(3, 1'b0, 1'b1);

    // lock first sampled at edge 10 -> first RUN cycle at edge 16
    applyStimulus(9, 1'b1, 1'b1);
    go_to(15);
    checkOutput("settle.pre_running", 32'(running), 32'd0);

    de_acc = 0; hs_acc = 0; vs_acc = 0;
    for (int e = 16; e <= 431; e++) begin
      go_to(e);
      if (de) de_acc++;
      if (!hsync) hs_acc++;
      if (!vsync) vs_acc++;
      if (e == 16) begin
        checkOutput("settle.running", 32'(running), 32'd1);
        checkOutput("settle.frame_start", 32'(frame_start), 32'd1);
        checkOutput("settle.line_start", 32'(line_start), 32'd1);
        checkOutput("settle.de", 32'(de), 32'd1);
      end
      if (e == 17) begin
        checkOutput("settle.x1", 32'(x), 32'd1);
        checkOutput("settle.fs_drop", 32'(frame_start), 32'd0);
      end
      if (e == 35) checkOutput("h.de_last", 32'(de), 32'd1);
      if (e == 36) checkOutput("h.de_off", 32'(de), 32'd0);
      if (e == 38) checkOutput("h.hs_before", 32'(hsync), 32'd1);
      if (e == 39) checkOutput("h.hs_first", 32'(hsync), 32'd0);
      if (e == 43) checkOutput("h.hs_last", 32'(hsync), 32'd0);
      if (e == 44) checkOutput("h.hs_after", 32'(hsync), 32'd1);
      if (e == 48) begin
        checkOutput("h.line_start", 32'(line_start), 32'd1);
        checkOutput("h.line_y", 32'(y), 32'd1);
        checkOutput("h.not_frame", 32'(frame_start), 32'd0);
      end
      if (e == 208) checkOutput("v.de_blank", 32'(de), 32'd0);
      if (e == 271) checkOutput("v.vs_before", 32'(vsync), 32'd1);
      if (e == 272) checkOutput("v.vs_first", 32'(vsync), 32'd0);
      if (e == 335) checkOutput("v.vs_last", 32'(vsync), 32'd0);
      if (e == 336) checkOutput("v.vs_after", 32'(vsync), 32'd1);
    end
    checkOutput("frame.de_count", 32'(de_acc), 32'd120);
    checkOutput("frame.hs_count", 32'(hs_acc), 32'd65);
    checkOutput("frame.vs_count", 32'(vs_acc), 32'd64);
    go_to(432);
    checkOutput("frame.period", 32'(frame_start), 32'd1);
    checkOutput("frame.wrap_y", 32'(y), 32'd0);

    // lock loss mid-frame at x=10, y=3
    go_to(538);
    checkOutput("loss.at_x", 32'(x), 32'd10);
    checkOutput("loss.at_y", 32'(y), 32'd3);
    applyStimulus(538, 1'b0, 1'b1);
    go_to(540);
    checkOutput("loss.still_running", 32'(running), 32'd1);
    checkOutput("loss.x12", 32'(x), 32'd12);
    go_to(541);
    check_idle("loss");
    applyStimulus(545, 1'b1, 1'b1);
    go_to(551);
    checkOutput("relock.pre", 32'(running), 32'd0);
    go_to(552);
    checkOutput("relock.frame_start", 32'(frame_start), 32'd1);
    checkOutput("relock.y", 32'(y), 32'd0);

    // lock glitch: three high samples are not enough to leave settle
    applyStimulus(600, 1'b0, 1'b1);
    applyStimulus(609, 1'b1, 1'b1);
    applyStimulus(612, 1'b0, 1'b1);
    for (int e = 613; e <= 630; e++) begin
      go_to(e);
      checkOutput("glitch.running", 32'(running), 32'd0);
    end
    applyStimulus(639, 1'b1, 1'b1);
    go_to(645);
    checkOutput("glitch.relock_pre", 32'(running), 32'd0);
    go_to(646);
    checkOutput("glitch.relock_fs", 32'(frame_start), 32'd1);

    // reset mid-RUN with lock held high
    applyStimulus(700, 1'b1, 1'b0);
    go_to(701);
    check_idle("midreset");
    applyStimulus(701, 1'b1, 1'b1);
    go_to(707);
    checkOutput("midreset.pre", 32'(running), 32'd0);
    go_to(708);
    checkOutput("midreset.fs", 32'(frame_start), 32'd1);

`ifdef VGA_TIMING_FRAME_CNT_EN
    go_to(709);
    checkOutput("fcnt.first", 32'(frame_cnt), 32'd1);
    go_to(1956);
    checkOutput("fcnt.three", 32'(frame_cnt), 32'd3);
    applyStimulus(2000, 1'b0, 1'b1);
    go_to(2010);
    checkOutput("fcnt.loss_run", 32'(running), 32'd0);
    checkOutput("fcnt.retained", 32'(frame_cnt), 32'd4);
    applyStimulus(2010, 1'b1, 1'b1);
    go_to(2017);
    checkOutput("fcnt.relock_fs", 32'(frame_start), 32'd1);
    checkOutput("fcnt.relock_hold", 32'(frame_cnt), 32'd4);
    go_to(2018);
    checkOutput("fcnt.relock_inc", 32'(frame_cnt), 32'd5);
    applyStimulus(2030, 1'b1, 1'b0);
    go_to(2031);
    checkOutput("fcnt.cleared", 32'(frame_cnt), 32'd0);
    applyStimulus(2031, 1'b1, 1'b1);
`endif

    go_to(edge_no + 40);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator in the pixel clock domain, directly downstream of the display PLL.
- Consumes the 25 MHz pixel clock and the PLL lock indication.
- Holds the display idle until lock has been stable for a programmable settle time.
- Then produces hsync/vsync/data-enable and pixel coordinates for the game renderer and the TMDS encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_WAIT, 1024, clkp cycles lock must stay high before RUN (≥1)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clkp  in  1  pixel clock, 25 MHz
- rstn  in  1  synchronous active-low reset
- locked  in  1  PLL lock, asynchronous to clkp
- running  out  1  high while in RUN
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable (visible pixel)
- x  out  10  horizontal counter
- y  out  10  vertical counter
- line_start  out  1  one-cycle pulse at x=0 in RUN
- frame_start  out  1  one-cycle pulse at x=0, y=0 in RUN

Behaviour:
- One clock (clkp). Reset is synchronous and active-low (rstn). All outputs driven from flops.
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800)
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525)
  - Both must be ≤1024; otherwise elaboration fails via a generate-time error.
- Reset (rstn=0 at edge):
  - state=WAIT_LOCK; lock synchronizer cleared; settle counter=0.
  - x=0, y=0, de=0, running=0, line_start=0, frame_start=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- locked passes through a 2-flop synchronizer; lk = second-stage output.
- WAIT_LOCK:
  - All outputs held at reset values.
  - lk=1 -> SETTLE with settle counter=0.
- SETTLE:
  - Counter increments each cycle while lk=1.
  - lk=0 -> WAIT_LOCK, counter cleared.
  - Counter == LOCK_WAIT-1 with lk=1 -> RUN.
  - First RUN cycle presents x=0, y=0, running=1, line_start=1, frame_start=1.
  - End-to-end latency: if locked is first sampled high at edge N and stays high, the first RUN cycle begins at edge N+2+LOCK_WAIT.
- RUN:
  - x increments each cycle and wraps H_TOTAL-1 -> 0.
  - y increments on the x wrap and wraps V_TOTAL-1 -> 0; both wrap together at frame end.
- Output timing (all combinational functions of the counter value, registered so they align with the x/y shown in the same cycle):
  - de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync asserted (=HSYNC_POL) iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted (=VSYNC_POL) iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, for the whole line
- Lock loss in RUN:
  - lk=0 sampled -> next cycle state=WAIT_LOCK; all outputs return to reset values.
  - No attempt to finish the frame.
  - Relock restarts from SETTLE and frame start; no mid-frame resume.
- Reset mid-RUN: same as reset at power-up; takes priority over lk.
- Simultaneous events:
  - lk falling on the same cycle SETTLE would complete -> WAIT_LOCK wins.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt (16 bits).
  - Reset/WAIT_LOCK/SETTLE value 0.
  - Increments by 1 in the cycle after each frame_start pulse; wraps 65535 -> 0.
  - Not cleared on lock loss, only on rstn=0.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset: rstn=0 for 3 cycles with locked=1 -> x=0, y=0, de=0, running=0, hsync=1, vsync=1 (default polarity).
- Settle timing: LOCK_WAIT=4, locked rises and is first sampled at edge 10 -> running=1 and frame_start=1 first at edge 16; x=1 at edge 17.
- Lock glitch: LOCK_WAIT=4, locked high for 3 sampled cycles then low -> running never asserts; full settle restarts on next rise.
- Full frame: defaults, run 420000 cycles:
  - de count per frame = 307200
  - hsync low for exactly 96 cycles starting at x=656
  - vsync low for lines 490–491
  - frame_start period = 420000
- Lock loss mid-frame: drop locked at x=300, y=200 -> 3 edges later running=0, de=0, x=0, y=0; re-raise -> restart at frame_start.
- VGA_TIMING_FRAME_CNT_EN: 3 complete frames -> frame_cnt=3. Lock loss then relock -> value retained. rstn pulse -> 0.
